// File: rtl/uart_rx_core.sv
// uart_rx_core
// Serial receive engine for the UART. It recovers 8N1 frames from rx_d using
// 16x oversampling with mid-bit sampling, then queues the received bytes in a
// small FIFO that the host pops with ld_rx_data.
//
// Ports:
//   clk_i        system clock, all state changes on the rising edge
//   rst_i        asynchronous active-low reset
//   baud_rate_i  rate select; 3'b111 fastest, each step down halves the rate
//   rx_d         asynchronous serial line, idle high
//   ld_rx_data   pop request, honoured only while rx_empty = 0
//   rx_data      byte popped most recently (registered)
//   rx_empty     FIFO holds no bytes
//   rx_full      FIFO holds 2**FIFO_AW bytes
//   frame_err    sticky, a stop bit was sampled low
//   overrun_err  sticky, a byte was dropped because the FIFO was full
//   clr_err_i    synchronous clear of both sticky flags
module uart_rx_core #(
  parameter int BASE_DIV = 2,
  parameter int FIFO_AW  = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] baud_rate_i,
  input  logic       rx_d,
  input  logic       ld_rx_data,
  output logic [7:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       frame_err,
  output logic       overrun_err,
  input  logic       clr_err_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = $clog2(BASE_DIV * 128) + 1;
  localparam int CW    = FIFO_AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t             state_q, state_d;
  logic               rx_meta, rx_s, rx_prev;
  logic               fall;
  logic [PW-1:0]      per_q, per_next, div_cnt_q;
  logic               tick;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               push, frame_set;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]      count;
  logic               pop_ok, push_ok, overrun_set;

  // Two-flop synchronizer on the raw line plus one more flop of history so a
  // falling edge can be seen. All flops idle high so reset never fakes a start.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_d;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall     = rx_prev & ~rx_s;
  assign per_next = PW'(BASE_DIV) << (3'd7 - baud_rate_i);
  assign tick     = (state_q != ST_IDLE) && (div_cnt_q == per_q - PW'(1));

  // Oversample tick divider. The period is captured at start detect so a
  // baud change during a frame only affects the next one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      per_q     <= PW'(BASE_DIV);
      div_cnt_q <= '0;
    end else if (state_q == ST_IDLE) begin
      div_cnt_q <= '0;
      if (fall) per_q <= per_next;
    end else begin
      div_cnt_q <= tick ? '0 : div_cnt_q + PW'(1);
    end
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
    end
  end

  // Next-state logic. START samples at the 8th tick (middle of the start
  // bit); every later sample is 16 ticks on, i.e. in the middle of each bit.
  // STOP returns to IDLE on the sampling clock so a following start edge
  // immediately after a one-bit stop is not missed.
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_set  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d    = ST_START;
          tick_cnt_d = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            bit_idx_d  = '0;
            state_d    = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d         = '0;
            shift_d[bit_idx_q] = rx_s;
            if (bit_idx_q == 3'd7) state_d = ST_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = '0;
            push       = rx_s;
            frame_set  = ~rx_s;
            state_d    = ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A pop needs a byte present; a push into a full FIFO only succeeds when a
  // pop frees a slot in the same cycle, otherwise the byte is dropped.
  assign rx_empty    = (count == '0);
  assign rx_full     = (count == CW'(DEPTH));
  assign pop_ok      = ld_rx_data & ~rx_empty;
  assign push_ok     = push & (~rx_full | pop_ok);
  assign overrun_set = push & rx_full & ~pop_ok;

  // FIFO storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift_q;
  end

  // FIFO pointers, occupancy and the registered output byte.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rx_data <= 8'h00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + FIFO_AW'(1);
        rx_data <= mem[rd_ptr];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (clr_err_i) frame_err <= 1'b0;
      if (overrun_set)    overrun_err <= 1'b1;
      else if (clr_err_i) overrun_err <= 1'b0;
    end
  end

endmodule
